// File: rtl/tinyqv_uart_tx_periph.sv
// tinyqv_uart_tx_periph
//   Buffered 8N1 UART transmitter on the TinyQV non-memory data interface.
//   The CPU pushes bytes into a small TX FIFO and a bit-timing FSM shifts
//   them out on uart_txd: start bit, eight data bits LSB first, stop bit.
//
//   Register map (data_addr[3:2]):
//     0x0 TXDATA   W: push data_in[7:0]          R: 0
//     0x4 STATUS   R: [0] full [1] empty [2] busy [8:4] FIFO count
//     0x8 DIVIDER  R/W [15:0]; bit time = DIVIDER+1 clocks
//     0xC          R: 0, writes ignored
//
//   Ports
//     clk, rst        clock, asynchronous active-high reset
//     data_addr       byte address; [3:2] selects register
//     data_write_n    11 = no write, otherwise write (any width)
//     data_read_n     11 = no read, otherwise read
//     data_in         write data
//     data_out        read data (combinational, valid with data_ready)
//     data_ready      transaction complete (combinational)
//     uart_txd        serial output, idle high (registered)
//     tx_empty_irq    FIFO empty and transmitter idle (registered)
//
//   Handshake: a request is any access with data_write_n or data_read_n
//   not 11. data_ready answers in the same cycle, except a TXDATA write
//   into a full FIFO with no pop that cycle, which waits. A write takes
//   effect on the edge where request && data_ready && !accept_q; accept_q
//   then holds until the bus goes idle so a held request acts only once.
module tinyqv_uart_tx_periph #(
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_RESET  = 555
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  data_addr,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        data_ready,
    output logic        uart_txd,
    output logic        tx_empty_irq
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t        state_q, state_d;
    logic [7:0]    fifo_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [15:0]   timer_q, timer_d;
    logic [15:0]   bit_div_q, bit_div_d;
    logic [15:0]   div_q;
    logic          txd_q, txd_d;
    logic          irq_q, irq_d;
    logic          accept_q;

    logic          wr_req, rd_req, req;
    logic [1:0]    reg_sel;
    logic          fifo_full, fifo_empty;
    logic          push, pop, do_write, bit_end;
    logic [4:0]    count_ext;
    logic          unused_bits;

    assign unused_bits = ^{data_in[31:16], data_addr[1:0]};

    // ---------------- bus side ----------------
    assign wr_req     = data_write_n != 2'b11;
    assign rd_req     = data_read_n != 2'b11;
    assign req        = wr_req | rd_req;
    assign reg_sel    = data_addr[3:2];
    assign fifo_full  = count_q == CW'(FIFO_DEPTH);
    assign fifo_empty = count_q == '0;
    assign count_ext  = 5'(count_q);

    // A pop in the same cycle frees a slot, so a full-FIFO write completes.
    assign data_ready = req && (accept_q || !(wr_req && reg_sel == 2'd0 && fifo_full && !pop));
    assign do_write   = wr_req && data_ready && !accept_q;
    assign push       = do_write && reg_sel == 2'd0;

    // Read and write together is a write, so reads are muted then.
    always_comb begin
        data_out = '0;
        if (rd_req && !wr_req) begin
            case (reg_sel)
                2'd1:    data_out = {23'd0, count_ext, 1'b0, (state_q != S_IDLE), fifo_empty, fifo_full};
                2'd2:    data_out = {16'd0, div_q};
                default: data_out = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            accept_q <= 1'b0;
            div_q    <= 16'(DIV_RESET);
        end else begin
            if (!req) accept_q <= 1'b0;
            else if (data_ready) accept_q <= 1'b1;
            if (do_write && reg_sel == 2'd2) div_q <= data_in[15:0];
        end
    end

    // ---------------- FIFO ----------------
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
        end
    end

    // Storage needs no reset; count_q decides which entries are live.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= data_in[7:0];
    end

    // ---------------- transmit FSM ----------------
    assign bit_end = timer_q == bit_div_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            timer_q   <= '0;
            bit_div_q <= 16'(DIV_RESET);
            txd_q     <= 1'b1;
            irq_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            timer_q   <= timer_d;
            bit_div_q <= bit_div_d;
            txd_q     <= txd_d;
            irq_q     <= irq_d;
        end
    end

    // The divider is sampled into bit_div_q at every bit boundary, so a
    // DIVIDER write never stretches or shortens the bit in flight.
    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        timer_d   = timer_q;
        bit_div_d = bit_div_q;
        if (state_q == S_IDLE) begin
            if (!fifo_empty) begin
                state_d   = S_START;
                pop       = 1'b1;
                shift_d   = fifo_q[rd_ptr_q];
                timer_d   = '0;
                bit_div_d = div_q;
            end
        end else if (!bit_end) begin
            timer_d = timer_q + 16'd1;
        end else begin
            timer_d   = '0;
            bit_div_d = div_q;
            case (state_q)
                S_START: begin
                    state_d   = S_DATA;
                    bit_idx_d = '0;
                end
                S_DATA: begin
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = shift_q >> 1;
                    end
                end
                S_STOP: begin
                    // Back-to-back frames: go straight to the next start bit.
                    if (!fifo_empty) begin
                        state_d = S_START;
                        pop     = 1'b1;
                        shift_d = fifo_q[rd_ptr_q];
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs are registered from next-state values so uart_txd changes
    // exactly on the bit boundary edge.
    always_comb begin
        txd_d = 1'b1;
        case (state_d)
            S_START: txd_d = 1'b0;
            S_DATA:  txd_d = shift_d[0];
            default: txd_d = 1'b1;
        endcase
        irq_d = (count_d == '0) && (state_d == S_IDLE);
    end

    assign uart_txd     = txd_q;
    assign tx_empty_irq = irq_q;

endmodule

// File: tb/tb_tinyqv_uart_tx_periph.sv
module tb_tinyqv_uart_tx_periph;

    localparam int WAIT_LIMIT  = 5000;
    localparam int DRAIN_LIMIT = 20000;

    logic        clk;
    logic        rst;
    logic [3:0]  data_addr;
    logic [1:0]  data_write_n;
    logic [1:0]  data_read_n;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        data_ready;
    logic        uart_txd;
    logic        tx_empty_irq;

    int vectors;
    int miscompares;
    int cyc;
    int mon_div;
    logic [7:0] exp_q[$];
    int f_start[$];
    int f_end[$];

    tinyqv_uart_tx_periph #(.FIFO_DEPTH(4), .DIV_RESET(555)) dut (
        .clk          (clk),
        .rst          (rst),
        .data_addr    (data_addr),
        .data_write_n (data_write_n),
        .data_read_n  (data_read_n),
        .data_in      (data_in),
        .data_out     (data_out),
        .data_ready   (data_ready),
        .uart_txd     (uart_txd),
        .tx_empty_irq (tx_empty_irq)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        cyc = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Line decoder: reconstructs a frame from the wire and demands every
    // bit be constant for exactly mon_div+1 clocks.
    task automatic decode_frame();
        logic [9:0] bits;
        logic       bad;
        int         s_cyc;
        bits  = '0;
        bad   = 1'b0;
        s_cyc = cyc;
        for (int b = 0; b < 10; b++) begin
            for (int k = 0; k <= mon_div; k++) begin
                if (b != 0 || k != 0) @(negedge clk);
                if (rst) return;
                if (k == 0) bits[b] = uart_txd;
                else if (uart_txd !== bits[b]) bad = 1'b1;
            end
        end
        f_start.push_back(s_cyc);
        f_end.push_back(cyc);
        check("frame_bit_timing", {31'd0, bad}, 32'd0);
        check("frame_stop_bit", {31'd0, bits[9]}, 32'd1);
        check("frame_expected", {31'd0, (exp_q.size() != 0)}, 32'd1);
        if (exp_q.size() != 0) check("frame_data", {24'd0, bits[8:1]}, {24'd0, exp_q.pop_front()});
    endtask

    initial begin : line_monitor
        logic prev;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (rst) prev = 1'b1;
            else if (prev === 1'b1 && uart_txd === 1'b0) begin
                decode_frame();
                prev = 1'b1;
            end else prev = uart_txd;
        end
    end

    // ---------------- driver tasks (called at a falling edge) ----------------
    task automatic bus_write(input logic [3:0] addr, input logic [31:0] data, output int waits);
        data_addr    = addr;
        data_in      = data;
        data_write_n = 2'b00;
        waits        = 0;
        #1;
        while (data_ready !== 1'b1 && waits < WAIT_LIMIT) begin
            @(negedge clk);
            #1;
            waits++;
        end
        check("write_ready", {31'd0, data_ready}, 32'd1);
        @(posedge clk);
        if (data_ready === 1'b1 && addr[3:2] == 2'd0) exp_q.push_back(data[7:0]);
        @(negedge clk);
        data_write_n = 2'b11;
        @(negedge clk);
    endtask

    task automatic bus_read(input logic [3:0] addr, output logic [31:0] data);
        data_addr   = addr;
        data_read_n = 2'b00;
        #1;
        check("read_ready", {31'd0, data_ready}, 32'd1);
        data = data_out;
        @(negedge clk);
        data_read_n = 2'b11;
        @(negedge clk);
    endtask

    task automatic check_read(input string tag, input logic [3:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(addr, d);
        check(tag, d, exp);
    endtask

    task automatic wr(input logic [3:0] addr, input logic [31:0] data);
        int w;
        bus_write(addr, data, w);
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (!(tx_empty_irq === 1'b1 && exp_q.size() == 0) && n < DRAIN_LIMIT) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_drained"}, {31'd0, (exp_q.size() == 0 && tx_empty_irq === 1'b1)}, 32'd1);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin : stimulus
        int w;
        int s0;
        int nbytes;
        logic [15:0] dv;
        vectors      = 0;
        miscompares  = 0;
        mon_div      = 555;
        rst          = 1'b1;
        data_addr    = '0;
        data_in      = '0;
        data_write_n = 2'b11;
        data_read_n  = 2'b11;

        // Reset state
        #1;
        check("rst_txd", {31'd0, uart_txd}, 32'd1);
        check("rst_irq", {31'd0, tx_empty_irq}, 32'd1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_status", 32'(0), 32'(0) + 0) ;
        check_read("rst_status_read", 4'h4, 32'h0000_0002);
        check_read("rst_divider", 4'h8, 32'd555);
        check_read("txdata_reads_0", 4'h0, 32'd0);
        check_read("reg_c_reads_0", 4'hC, 32'd0);

        // DIVIDER upper bits dropped; simultaneous read+write acts as write
        wr(4'h8, 32'hABCD_1234);
        check_read("div_upper_masked", 4'h8, 32'h0000_1234);
        data_addr = 4'h8; data_in = 32'd7; data_write_n = 2'b01; data_read_n = 2'b00;
        #1;
        check("rw_both_ready", {31'd0, data_ready}, 32'd1);
        check("rw_both_dout", data_out, 32'd0);
        @(negedge clk);
        data_write_n = 2'b11; data_read_n = 2'b11;
        @(negedge clk);
        check_read("rw_both_wrote", 4'h8, 32'd7);
        wr(4'hC, 32'hFFFF_FFFF);
        wr(4'h4, 32'hFFFF_FFFF);
        check_read("ignored_writes", 4'h4, 32'h0000_0002);

        // 0x55 at DIVIDER=3: 10 bits x 4 clocks
        wr(4'h8, 32'd3);
        mon_div = 3;
        s0 = f_start.size();
        wr(4'h0, 32'h0000_0055);
        check("irq_low_in_frame", {31'd0, tx_empty_irq}, 32'd0);
        check_read("status_busy", 4'h4, 32'h0000_0006);
        wait_drain("f55");
        check("f55_len", f_end[s0] - f_start[s0] + 1, 32'd40);
        check("f55_irq_after", {31'd0, tx_empty_irq}, 32'd1);

        // DIVIDER=100, six back-to-back writes, the sixth stalls for a frame
        wr(4'h8, 32'd100);
        mon_div = 100;
        for (int i = 0; i < 5; i++) wr(4'h0, 32'h10 + 32'(i));
        check_read("full_status", 4'h4, 32'h0000_0045);
        bus_write(4'h0, 32'h15, w);
        check("w6_waited", {31'd0, (w >= 980 && w <= 1010)}, 32'd1);
        check_read("full_after_pop_push", 4'h4, 32'h0000_0045);
        wait_drain("six");

        // Held request after ready: exactly one frame
        wr(4'h8, 32'd3);
        mon_div = 3;
        s0 = f_start.size();
        data_addr = 4'h0; data_in = 32'hA3; data_write_n = 2'b00;
        #1;
        check("hold_ready", {31'd0, data_ready}, 32'd1);
        @(posedge clk);
        exp_q.push_back(8'hA3);
        repeat (5) @(negedge clk);
        data_write_n = 2'b11;
        @(negedge clk);
        wait_drain("hold");
        repeat (60) @(negedge clk);
        check("hold_one_frame", f_start.size() - s0, 32'd1);

        // 0x01 then 0xFF at DIVIDER=1: no gap, 40 clocks total
        wr(4'h8, 32'd1);
        mon_div = 1;
        s0 = f_start.size();
        wr(4'h0, 32'h01);
        wr(4'h0, 32'hFF);
        wait_drain("b2b");
        check("b2b_frames", f_start.size() - s0, 32'd2);
        if (f_start.size() - s0 == 2) begin
            check("b2b_no_gap", f_start[s0+1] - f_end[s0], 32'd1);
            check("b2b_total", f_end[s0+1] - f_start[s0] + 1, 32'd40);
        end

        // Randomized bursts against the queue model
        for (int it = 0; it < 8; it++) begin
            dv = 16'($urandom_range(0, 7));
            wr(4'h8, {16'hFFFF, dv});
            mon_div = int'(dv);
            check_read("rand_div", 4'h8, {16'd0, dv});
            s0 = f_start.size();
            nbytes = $urandom_range(1, 6);
            for (int j = 0; j < nbytes; j++) wr(4'h0, $urandom());
            wait_drain("rand");
            check("rand_frames", f_start.size() - s0, 32'(nbytes));
            check_read("rand_status", 4'h4, 32'h0000_0002);
        end

        // Reset in the middle of a data bit
        wr(4'h8, 32'd3);
        mon_div = 3;
        s0 = f_start.size();
        wr(4'h0, 32'hF0);
        wr(4'h0, 32'h33);
        wr(4'h0, 32'h5A);
        repeat (3) @(negedge clk);
        check("pre_rst_txd", {31'd0, uart_txd}, 32'd0);
        check("pre_rst_irq", {31'd0, tx_empty_irq}, 32'd0);
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("rst_mid_txd", {31'd0, uart_txd}, 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_read("post_rst_status", 4'h4, 32'h0000_0002);
        check_read("post_rst_div", 4'h8, 32'd555);
        repeat (200) @(negedge clk);
        check("post_rst_no_frame", f_start.size() - s0, 32'd0);
        check("post_rst_txd", {31'd0, uart_txd}, 32'd1);
        check("post_rst_irq", {31'd0, tx_empty_irq}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
